// File: rtl/modulo_controlador_contador_5_bits.sv
// Sequencing controller for the 5-bit up/down T-flip-flop counter.
// Runs load -> count -> terminal cycles with pause, abort and an optional tick prescaler.
module modulo_controlador_contador_5_bits #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned TICK_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    input  logic [4:0] preset,
    input  logic [4:0] limit,
    input  logic [4:0] q,
    output logic       cnt_enable,
    output logic       cnt_up_down,
    output logic       cnt_load,
    output logic [4:0] cnt_e_load,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            st;
    state_t            nxt;
    logic [4:0]        limit_c;
    logic [TICK_W-1:0] presc;
    logic              tick;
    logic              at_limit;

    assign tick     = (presc == TICK_W'(TICK_DIV - 1));
    assign at_limit = (q == limit_c);

    always_comb begin
        nxt        = st;
        cnt_enable = 1'b0;
        case (st)
            S_INIT:  nxt = S_IDLE;
            S_IDLE:  if (start && !stop) nxt = S_LOAD;
            S_LOAD:  nxt = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (stop)          nxt = S_IDLE;
                else if (at_limit) nxt = S_DONE;
                else if (pause)    nxt = S_PAUSE;
                else               cnt_enable = tick;
            end
            S_PAUSE: begin
                if (stop)        nxt = S_IDLE;
                else if (!pause) nxt = S_RUN;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_INIT;
            cnt_load    <= 1'b1;
            cnt_e_load  <= '0;
            cnt_up_down <= 1'b0;
            limit_c     <= '0;
            presc       <= '0;
        end else begin
            st <= nxt;
            // load strobe is a flop decoded from the next state, so it never glitches
            cnt_load <= (nxt == S_INIT) || (nxt == S_LOAD);
            if (st == S_IDLE && nxt == S_LOAD) begin
                cnt_up_down <= dir;
                cnt_e_load  <= preset;
                limit_c     <= limit;
            end
            if (st == S_LOAD)
                presc <= '0;
            else if (st == S_RUN && nxt == S_RUN)
                presc <= tick ? '0 : presc + 1'b1;
        end
    end

    assign busy  = (st == S_LOAD) || (st == S_RUN) || (st == S_PAUSE);
    assign done  = (st == S_DONE);
    assign state = st;

endmodule

// File: tb/tb_modulo_controlador_contador_5_bits.sv
// Scoreboard bench: per-cycle expectations are queued by the stimulus and checked by a negedge monitor.
// A behavioural counter (async load modelled as a mux) closes the q feedback loop for each instance.
module tb_modulo_controlador_contador_5_bits;

    logic       clk = 1'b0;
    logic       reset, start, stop, pause, dir;
    logic [4:0] preset, limit;

    logic       en0, ud0, ld0, busy0, done0;
    logic [4:0] el0, q0, qr0;
    logic [2:0] st0;
    logic       en1, ud1, ld1, busy1, done1;
    logic [4:0] el1, q1, qr1;
    logic [2:0] st1;

    always #5 clk = ~clk;

    modulo_controlador_contador_5_bits #(.TICK_DIV(1), .TICK_W(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .dir(dir),
        .preset(preset), .limit(limit), .q(q0), .cnt_enable(en0), .cnt_up_down(ud0),
        .cnt_load(ld0), .cnt_e_load(el0), .busy(busy0), .done(done0), .state(st0)
    );

    modulo_controlador_contador_5_bits #(.TICK_DIV(3), .TICK_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .dir(dir),
        .preset(preset), .limit(limit), .q(q1), .cnt_enable(en1), .cnt_up_down(ud1),
        .cnt_load(ld1), .cnt_e_load(el1), .busy(busy1), .done(done1), .state(st1)
    );

    assign q0 = ld0 ? el0 : qr0;
    assign q1 = ld1 ? el1 : qr1;

    always @(posedge clk) begin
        if (ld0)      qr0 <= el0;
        else if (en0) qr0 <= ud0 ? qr0 + 5'd1 : qr0 - 5'd1;
        if (ld1)      qr1 <= el1;
        else if (en1) qr1 <= ud1 ? qr1 + 5'd1 : qr1 - 5'd1;
    end

    typedef struct {
        string      nm;
        bit         sel;
        logic [2:0] st;
        logic [4:0] q;
        logic       en;
        logic       ld;
        logic [4:0] el;
        logic       ud;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic [4:0] cur_pre = '0;
    logic       cur_dir = 1'b0;
    bit         sel     = 1'b0;

    localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, LOAD = 3'd2, RUN = 3'd3, PAUSE = 3'd4, DONE = 3'd5;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [2:0] a_st;
            logic [4:0] a_q, a_el;
            logic       a_en, a_ld, a_ud, a_busy, a_done;
            e = sb.pop_front();
            if (e.sel) begin
                a_st = st1; a_q = q1; a_en = en1; a_ld = ld1; a_el = el1; a_ud = ud1; a_busy = busy1; a_done = done1;
            end else begin
                a_st = st0; a_q = q0; a_en = en0; a_ld = ld0; a_el = el0; a_ud = ud0; a_busy = busy0; a_done = done0;
            end
            compared++;
            if (a_st !== e.st || a_q !== e.q || a_en !== e.en || a_ld !== e.ld || a_el !== e.el ||
                a_ud !== e.ud || a_busy !== e.busy || a_done !== e.done) begin
                mismatched++;
                $display("FAIL %s: got st=%0d q=%0d en=%b ld=%b el=%0d ud=%b busy=%b done=%b, want st=%0d q=%0d en=%b ld=%b el=%0d ud=%b busy=%b done=%b",
                         e.nm, a_st, a_q, a_en, a_ld, a_el, a_ud, a_busy, a_done,
                         e.st, e.q, e.en, e.ld, e.el, e.ud, e.busy, e.done);
            end
        end
    end

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic [2:0] s, input logic [4:0] qv, input logic en);
        exp_t e;
        e.nm   = nm;
        e.sel  = sel;
        e.st   = s;
        e.q    = qv;
        e.en   = en;
        e.ld   = (s == INIT) || (s == LOAD);
        e.el   = cur_pre;
        e.ud   = cur_dir;
        e.busy = (s == LOAD) || (s == RUN) || (s == PAUSE);
        e.done = (s == DONE);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic skip();
        @(posedge clk); #1;
    endtask

    task automatic begin_cycle(input logic d, input logic [4:0] p, input logic [4:0] l, input logic [4:0] qnow);
        dir = d; preset = p; limit = l; start = 1'b1;
        cyc("start_idle", IDLE, qnow, 1'b0);
        start = 1'b0;
        cur_pre = p; cur_dir = d;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0; preset = '0; limit = '0;
        skip();
        cyc("rst_hold", INIT, 5'd0, 1'b0);
        reset = 1'b0;
        cyc("init", INIT, 5'd0, 1'b0);
        cyc("idle", IDLE, 5'd0, 1'b0);

        // Up 3 -> 7, with late input changes and busy/done-time starts that must be ignored
        begin_cycle(1'b1, 5'd3, 5'd7, 5'd0);
        dir = 1'b0; preset = 5'd20; limit = 5'd1;
        cyc("up_load", LOAD, 5'd3, 1'b0);
        cyc("up_r3", RUN, 5'd3, 1'b1);
        start = 1'b1;
        cyc("up_r4", RUN, 5'd4, 1'b1);
        start = 1'b0;
        cyc("up_r5", RUN, 5'd5, 1'b1);
        cyc("up_r6", RUN, 5'd6, 1'b1);
        cyc("up_term", RUN, 5'd7, 1'b0);
        start = 1'b1;
        cyc("up_done", DONE, 5'd7, 1'b0);
        start = 1'b0;
        cyc("up_idle", IDLE, 5'd7, 1'b0);

        // Down 1 -> 30 through the 0 -> 31 wrap
        begin_cycle(1'b0, 5'd1, 5'd30, 5'd7);
        cyc("dn_load", LOAD, 5'd1, 1'b0);
        cyc("dn_r1", RUN, 5'd1, 1'b1);
        cyc("dn_r0", RUN, 5'd0, 1'b1);
        cyc("dn_r31", RUN, 5'd31, 1'b1);
        cyc("dn_term", RUN, 5'd30, 1'b0);
        cyc("dn_done", DONE, 5'd30, 1'b0);
        cyc("dn_idle", IDLE, 5'd30, 1'b0);

        // Up 0 -> 10 with a three-cycle pause at q=4
        begin_cycle(1'b1, 5'd0, 5'd10, 5'd30);
        cyc("pa_load", LOAD, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("pa_run", RUN, 5'(i), 1'b1);
        pause = 1'b1;
        cyc("pa_enter", RUN, 5'd4, 1'b0);
        cyc("pa_hold1", PAUSE, 5'd4, 1'b0);
        cyc("pa_hold2", PAUSE, 5'd4, 1'b0);
        pause = 1'b0;
        cyc("pa_exit", PAUSE, 5'd4, 1'b0);
        for (int i = 4; i < 10; i++) cyc("pa_resume", RUN, 5'(i), 1'b1);
        cyc("pa_term", RUN, 5'd10, 1'b0);
        cyc("pa_done", DONE, 5'd10, 1'b0);
        cyc("pa_idle", IDLE, 5'd10, 1'b0);

        // Same count aborted at q=6; stop together with start in IDLE stays idle
        begin_cycle(1'b1, 5'd0, 5'd10, 5'd10);
        cyc("st_load", LOAD, 5'd0, 1'b0);
        for (int i = 0; i < 6; i++) cyc("st_run", RUN, 5'(i), 1'b1);
        stop = 1'b1;
        cyc("st_abort", RUN, 5'd6, 1'b0);
        start = 1'b1;
        cyc("st_idle", IDLE, 5'd6, 1'b0);
        start = 1'b0; stop = 1'b0;
        cyc("st_still_idle", IDLE, 5'd6, 1'b0);

        // preset == limit: no steps
        begin_cycle(1'b1, 5'd9, 5'd9, 5'd6);
        cyc("eq_load", LOAD, 5'd9, 1'b0);
        cyc("eq_run", RUN, 5'd9, 1'b0);
        cyc("eq_done", DONE, 5'd9, 1'b0);
        cyc("eq_idle", IDLE, 5'd9, 1'b0);

        // Reset in the middle of a run
        begin_cycle(1'b1, 5'd0, 5'd20, 5'd9);
        cyc("rr_load", LOAD, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("rr_run", RUN, 5'(i), 1'b1);
        reset = 1'b1;
        cyc("rr_run3", RUN, 5'd3, 1'b1);
        reset = 1'b0;
        cur_pre = '0; cur_dir = 1'b0;
        cyc("rr_init", INIT, 5'd0, 1'b0);
        cyc("rr_idle", IDLE, 5'd0, 1'b0);

        // TICK_DIV=3 instance: up 0 -> 2, DONE seven cycles after entering RUN
        reset = 1'b1;
        skip();
        reset = 1'b0;
        sel = 1'b1;
        cyc("t3_init", INIT, 5'd0, 1'b0);
        begin_cycle(1'b1, 5'd0, 5'd2, 5'd0);
        cyc("t3_load", LOAD, 5'd0, 1'b0);
        cyc("t3_a0", RUN, 5'd0, 1'b0);
        cyc("t3_a1", RUN, 5'd0, 1'b0);
        cyc("t3_a2", RUN, 5'd0, 1'b1);
        cyc("t3_b0", RUN, 5'd1, 1'b0);
        cyc("t3_b1", RUN, 5'd1, 1'b0);
        cyc("t3_b2", RUN, 5'd1, 1'b1);
        cyc("t3_term", RUN, 5'd2, 1'b0);
        cyc("t3_done", DONE, 5'd2, 1'b0);
        cyc("t3_idle", IDLE, 5'd2, 1'b0);

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/modulo_controlador_contador_5_bits.md
Name: modulo_controlador_contador_5_bits

Overview:
Sequencing controller for the 5-bit synchronous up/down counter (T flip-flop datapath with load-driven asynchronous preset/clear and clock-enable). It captures a start request and runs a load→count→terminal cycle, stopping the counter at a programmable limit in either direction. It supports pause/resume, abort and an optional tick prescaler. It sits between user/FSM control logic and the counter, driving the counter's enable, up_down, load and e_load inputs and reading back q.

Parameters:
TICK_DIV, 1, counter steps once every TICK_DIV clk cycles while running (legal range 1..255).
TICK_W, 8, width of the internal prescaler register; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a count cycle; sampled only in IDLE.
stop  input  1  abort; returns to IDLE from any state.
pause  input  1  level; freezes counting while high in RUN/PAUSE.
dir  input  1  1 = count up, 0 = count down; captured at start.
preset  input  5  initial counter value; captured at start.
limit  input  5  terminal counter value; captured at start.
q  input  5  current counter value, fed back from the counter.
cnt_enable  output  1  counter enable; combinational.
cnt_up_down  output  1  counter direction (1 = up); registered.
cnt_load  output  1  counter load strobe; registered, glitch-free.
cnt_e_load  output  5  counter load value; registered.
busy  output  1  high in LOAD, RUN and PAUSE.
done  output  1  one-cycle pulse in DONE.
state  output  3  state code: INIT=0, IDLE=1, LOAD=2, RUN=3, PAUSE=4, DONE=5.

Behaviour:
- Reset (synchronous, active-high): state=INIT, cnt_load=1, cnt_e_load=0, cnt_up_down=0, busy=0, done=0, prescaler=0, captured dir/preset/limit registers=0.
- INIT: holds cnt_load=1 with cnt_e_load=0 for exactly one cycle, which clears the counter to 0. Next state is IDLE.
- IDLE: cnt_load=0. When start=1 and stop=0: capture dir, preset and limit; set cnt_up_down=dir and cnt_e_load=preset; go to LOAD.
- LOAD: one cycle with cnt_load=1, so the counter's asynchronous preset/clear forces q=preset. Next state is RUN with cnt_load=0 and prescaler=0.
- Define tick = (prescaler == TICK_DIV-1).
  - The prescaler increments every cycle in RUN while pause=0 and wraps to 0 on tick.
  - When TICK_DIV=1, tick is always 1.
- cnt_enable = (state==RUN) & ~pause & tick & (q != limit_captured). The counter steps on the same edge.
- RUN transitions:
  - q==limit_captured → DONE.
  - pause=1 → PAUSE, prescaler held.
  - Otherwise remain in RUN.
- PAUSE: cnt_enable=0. pause=0 → RUN; the prescaler resumes from its held value.
- DONE: done=1 for one cycle, then IDLE. A start during DONE is ignored.
- Priority: reset > stop > terminal (q==limit) > pause > tick.
  - stop in any state other than INIT → IDLE next edge, cnt_enable=0, q left as is, done not pulsed.
  - stop and start together in IDLE → stay in IDLE.
- preset==limit: LOAD → RUN → DONE with zero counter steps.
- Counting wraps modulo 32 (up: 31→0; down: 0→31). The limit is always reached, after at most 31 steps.
- Step count = (limit−preset) mod 32 for up, (preset−limit) mod 32 for down. RUN duration = steps×TICK_DIV cycles, plus 1 cycle for terminal detect.
- start while busy: ignored. dir/preset/limit changes after capture: ignored until the next start.
- Reset during RUN/PAUSE: INIT next cycle; the counter is cleared to 0 in INIT.

Test Plan:
- Reset 2 cycles, then release → state 0 for 1 cycle with cnt_load=1, cnt_e_load=0, so q=0; then state 1, busy=0.
- Up count: dir=1, preset=3, limit=7, start pulse → LOAD 1 cycle (q=3), q steps 4,5,6,7 on consecutive edges, then DONE with done=1 for 1 cycle, then IDLE with q holding 7.
- Down count with wrap: dir=0, preset=1, limit=30 → q sequence 1,0,31,30; cnt_enable low once q=30; done pulses exactly once.
- Pause/stop: up 0→10; pause high for 3 cycles at q=4 → q holds 4, state 4, cnt_enable=0; release → resumes to 10. Repeat, asserting stop at q=6 → IDLE, q stays 6, no done pulse.
- TICK_DIV=3, dir=1, preset=0, limit=2 → q increments every 3rd RUN cycle; done asserted 7 cycles after entering RUN.
- preset=limit=9 → LOAD, RUN, DONE with no cnt_enable pulse. Reset asserted mid-RUN of another count → INIT, then q=0, then IDLE.
